// File: rtl/bsg_nand_pipe_pkg.sv
// Shared types and constants for the bsg_nand_pipe_stage input buffer.
package bsg_nand_pipe_pkg;

  localparam int unsigned bsg_nand_pipe_els_gp       = 2;
  localparam int unsigned bsg_nand_pipe_cnt_width_gp = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } bsg_nand_pipe_state_e;

endpackage

// File: rtl/bsg_nand.sv
// Bitwise NAND of two operand vectors.
module bsg_nand #(
  parameter int unsigned width_p = 16
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] o
);

  assign o = ~(a_i & b_i);

endmodule

// File: rtl/bsg_nand_pipe_stage.sv
// Two-entry valid/ready -> valid/yumi buffer feeding bsg_nand.
// Define BSG_NAND_PIPE_STAGE_CNT_EN to add the 16-bit consumed-result counter on count_o.
module bsg_nand_pipe_stage
  import bsg_nand_pipe_pkg::*;
#(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] o,
  output logic               v_o,
  input  logic               yumi_i
`ifdef BSG_NAND_PIPE_STAGE_CNT_EN
  ,
  output logic [bsg_nand_pipe_cnt_width_gp-1:0] count_o
`endif
);

  bsg_nand_pipe_state_e state_q, state_d;
  logic                 rd_ptr_q, wr_ptr_q;
  logic                 ready_q, v_q;
  logic                 enq, deq;

  logic [width_p-1:0] a_mem_q [bsg_nand_pipe_els_gp];
  logic [width_p-1:0] b_mem_q [bsg_nand_pipe_els_gp];

  assign ready_o = ready_q;
  assign v_o     = v_q;

  // Dequeue is gated by v_q so a stray yumi on an empty buffer cannot corrupt state.
  assign enq = v_i & ready_q;
  assign deq = yumi_i & v_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (enq) state_d = ONE;
      ONE: begin
        if (enq && !deq) state_d = FULL;
        else if (deq && !enq) state_d = EMPTY;
      end
      FULL: if (deq) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_q ^ deq;
      wr_ptr_q <= wr_ptr_q ^ enq;
      ready_q  <= (state_d != FULL);
      v_q      <= (state_d != EMPTY);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) begin
      a_mem_q[wr_ptr_q] <= a_i;
      b_mem_q[wr_ptr_q] <= b_i;
    end
  end

  bsg_nand #(
    .width_p(width_p)
  ) u_nand (
    .a_i(a_mem_q[rd_ptr_q]),
    .b_i(b_mem_q[rd_ptr_q]),
    .o  (o)
  );

`ifdef BSG_NAND_PIPE_STAGE_CNT_EN
  logic [bsg_nand_pipe_cnt_width_gp-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else if (deq) count_q <= count_q + 1'b1;
  end

  assign count_o = count_q;
`endif

  yumi_needs_valid_a : assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_q);

endmodule

// File: tb/tb_bsg_nand_pipe_stage.sv
// Directed-vector and scoreboard bench for bsg_nand_pipe_stage.
module tb_bsg_nand_pipe_stage;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         v_i = 1'b0;
  logic         yumi_i = 1'b0;
  logic         ready_o, v_o;
  logic [W-1:0] o;
`ifdef BSG_NAND_PIPE_STAGE_CNT_EN
  logic [15:0]  count_o;
`endif

  always #5 clk = ~clk;

  bsg_nand_pipe_stage #(
    .width_p(W)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .v_i    (v_i),
    .ready_o(ready_o),
    .o      (o),
    .v_o    (v_o),
`ifdef BSG_NAND_PIPE_STAGE_CNT_EN
    .count_o(count_o),
`endif
    .yumi_i (yumi_i)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];
  logic [15:0]  cnt_exp = '0;
  int           deq_seen = 0;

  typedef struct {
    logic         v;
    logic         y;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         vo;
    logic         chk_o;
    logic [W-1:0] o;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle against the queue model: drive at negedge, check, then update model at posedge.
  task automatic step(input logic v, input logic y, input logic [W-1:0] a, input logic [W-1:0] b);
    logic enq, deq;
    @(negedge clk);
    v_i    = v;
    a_i    = a;
    b_i    = b;
    yumi_i = y && (sb.size() > 0);
    #1;
    chk("ready", ready_o, sb.size() < 2);
    chk("valid", v_o, sb.size() > 0);
    if (sb.size() > 0) chk("data", o, sb[0]);
`ifdef BSG_NAND_PIPE_STAGE_CNT_EN
    chk("count", count_o, cnt_exp);
`endif
    enq = v && (sb.size() < 2);
    deq = yumi_i;
    @(posedge clk);
    if (deq) begin
      void'(sb.pop_front());
      cnt_exp++;
      deq_seen++;
    end
    if (enq) sb.push_back(~(a & b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    v_i     = 1'b1;
    yumi_i  = 1'b1;
    a_i     = 16'hDEAD;
    b_i     = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    #1;
    chk("rst_valid", v_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
`ifdef BSG_NAND_PIPE_STAGE_CNT_EN
    chk("rst_count", count_o, 16'h0000);
`endif
    sb.delete();
    cnt_exp = '0;
  endtask

  initial begin
    //            v     y     a         b         ready vo    chk_o o
    vecs[0] = '{1'b1, 1'b0, 16'hFFFF, 16'h00F0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFF0F};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'hAAAA, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h5555};
    vecs[5] = '{1'b1, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1, 1'b1, 16'h5555};
    vecs[6] = '{1'b1, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1, 1'b1, 16'h5555};
    vecs[7] = '{1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1, 1'b1, 16'h5555};
    vecs[8] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFF};
    // Empty again; o shows the stale head (AAAA nand FFFF).
    vecs[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5555};

    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v_i    = vecs[i].v;
      yumi_i = vecs[i].y;
      a_i    = vecs[i].a;
      b_i    = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_ready", i), ready_o, vecs[i].ready);
      chk($sformatf("vec%0d_valid", i), v_o, vecs[i].vo);
      if (vecs[i].chk_o) chk($sformatf("vec%0d_o", i), o, vecs[i].o);
    end
    cnt_exp = 16'd3;

    // Streaming: 100 pairs, one result per cycle.
    deq_seen = 0;
    step(1'b1, 1'b0, W'($urandom), W'($urandom));
    for (int i = 0; i < 99; i++) step(1'b1, 1'b1, W'($urandom), W'($urandom));
    step(1'b0, 1'b1, '0, '0);
    chk("stream_results", deq_seen, 100);

    // Random backpressure.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, '0);
    chk("drain_empty", sb.size(), 0);

    // Reset while FULL, then the next accepted pair is the first result out.
    step(1'b1, 1'b0, 16'h1111, 16'h2222);
    step(1'b1, 1'b0, 16'h3333, 16'h4444);
    #1;
    chk("full_ready", ready_o, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 16'hF0F0, 16'hFF00);
    #1;
    chk("post_rst_first", o, 16'h0FFF);
    step(1'b0, 1'b1, '0, '0);

`ifdef BSG_NAND_PIPE_STAGE_CNT_EN
    do_reset();
    step(1'b1, 1'b0, W'($urandom), W'($urandom));
    for (int i = 0; i < 65535; i++) step(1'b1, 1'b1, W'($urandom), W'($urandom));
    #1;
    chk("cnt_ffff", count_o, 16'hFFFF);
    step(1'b1, 1'b1, W'($urandom), W'($urandom));
    #1;
    chk("cnt_wrap", count_o, 16'h0000);
    step(1'b0, 1'b1, '0, '0);
    #1;
    chk("cnt_one", count_o, 16'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
